// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, carry registered between cycles.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_s, fa_c;

    // Full-adder cell fed from the shift-register LSBs and the stored carry.
    always_comb begin
        fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {fa_s, res_sh_q[WIDTH-1:1]};
                carry_d  = fa_c;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    sum_d   = res_sh_d;
                    cout_d  = fa_c;
                    // Carry into the MSB is the stored carry at the final step.
                    ovf_d   = carry_q ^ fa_c;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed vectors, corner sequences, random.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, ovf_w;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef SERIAL_ADDER_OVF_EN
    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .ovf(ovf_w), .cout(cout)
    );
`else
    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );
    assign ovf_w = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer addition; overflow when same-sign operands give opposite-sign sum.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0] t;
        t  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        s  = t[W-1:0];
        co = t[W];
        ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    endtask

    // Issue one addition and wait (bounded) for done; returns result and timing.
    task automatic run_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                           output logic [W-1:0] s, output logic co, output logic ov,
                           output int lat, output int bcnt);
        @(negedge clk);
        a = x; b = y; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~x; b = ~y; cin = ~ci;
        lat = -1; bcnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        s = sum; co = cout; ov = ovf_w;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done within 40 cycles");
        end
    endtask

    initial begin
        logic [W-1:0] s, es;
        logic         co, ov, eco, eov;
        int           lat, bcnt, ndone;
        logic [W-1:0] opa[31], opb[31];
        logic         opc[31];

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_add(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, ov, lat, bcnt);
            check($sformatf("vec%0d_sum", i), s, vecs[i].sum);
            check($sformatf("vec%0d_cout", i), co, vecs[i].cout);
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("vec%0d_ovf", i), ov, vecs[i].ovf);
`endif
            check($sformatf("vec%0d_latency", i), lat, W);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, W);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), done, 0);
            check($sformatf("vec%0d_sum_hold", i), sum, vecs[i].sum);
        end

        // Requests during busy and during DONE are ignored.
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int t = 1; t < 30; t++) begin
            if (done) ndone++;
            if (t == 3 || (done && ndone == 1)) begin
                a = 8'hF0; b = 8'h0F; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ignore_sum", sum, 8'h02);
        check("ignore_cout", cout, 0);
        check("ignore_done_count", ndone, 1);

        // Start held high: back-to-back accepts spaced W+2 cycles apart.
        repeat (2) @(negedge clk);
        ndone = 0;
        for (int t = 0; t < 31; t++) begin
            if (done) begin
                check($sformatf("b2b%0d_time", ndone), t, ndone * (W + 2) + W + 1);
                if (t >= W + 1) begin
                    model(opa[t-W-1], opb[t-W-1], opc[t-W-1], es, eco, eov);
                    check($sformatf("b2b%0d_sum", ndone), sum, es);
                    check($sformatf("b2b%0d_cout", ndone), cout, eco);
                end
                ndone++;
            end
            opa[t] = W'($urandom); opb[t] = W'($urandom); opc[t] = 1'($urandom);
            a = opa[t]; b = opb[t]; cin = opc[t]; start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_done_count", ndone, 3);
        repeat (2 * W + 4) @(negedge clk);

        // Asynchronous reset mid-run discards the addition.
        run_add(8'hAA, 8'h11, 1'b0, s, co, ov, lat, bcnt);
        check("pre_reset_sum", s, 8'hBB);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_sum", sum, 0);
        check("arst_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int t = 0; t < 12; t++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        check("arst_no_activity", ndone, 0);
        run_add(8'h12, 8'h34, 1'b0, s, co, ov, lat, bcnt);
        check("post_reset_sum", s, 8'h46);
        check("post_reset_cout", co, 0);

        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] x, y;
            logic         c;
            x = W'($urandom); y = W'($urandom); c = 1'($urandom);
            model(x, y, c, es, eco, eov);
            run_add(x, y, c, s, co, ov, lat, bcnt);
            check($sformatf("rand%0d_sum", i), s, es);
            check($sformatf("rand%0d_cout", i), co, eco);
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("rand%0d_ovf", i), ov, eov);
`endif
            check($sformatf("rand%0d_latency", i), lat, W);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
